nibble_packer: RTL

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_pkg.sv | 30 +++
 rtl/nibble_packer_word_fifo2.sv | 48 ++++
 rtl/nibble_packer.sv | 101 ++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared widths, packer state encoding and the queued word layout for nibble_packer.
package nibble_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned LANES    = 4;
  localparam int unsigned BEAT_W   = NIBBLE_W * LANES;
  localparam int unsigned WORD_W   = 2 * BEAT_W;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } pack_state_t;

  typedef struct packed {
    logic              partial;
    logic [WORD_W-1:0] data;
  } word_entry_t;

  function automatic word_entry_t make_entry(
    input logic [BEAT_W-1:0] upper,
    input logic [BEAT_W-1:0] lower,
    input logic              partial
  );
    word_entry_t e;
    e.partial = partial;
    e.data    = {upper, lower};
    return e;
  endfunction

endpackage

// File: rtl/nibble_packer_word_fifo2.sv
// Two-entry output queue for packed words; head reads as zero while empty.
module word_fifo2
  import nibble_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  word_entry_t wr_data,
  input  logic        rd_en,
  output word_entry_t rd_data,
  output logic [1:0]  count
);

  word_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign do_rd = rd_en && (count != 2'd0);
  assign do_wr = wr_en && (count != 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/nibble_packer.sv
// Pairs 16-bit nibble beats into 32-bit words, with zero-padded flush of a held half.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET_L,
  input  logic [BEAT_W-1:0]  NIBBLE_IN,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic               FLUSH,
  output logic [WORD_W-1:0]  DATA_OUT,
  output logic               OUT_PARTIAL,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [COUNT_W-1:0] WORD_COUNT
);

  pack_state_t       state;
  pack_state_t       state_nxt;
  logic [BEAT_W-1:0] low_half;
  logic              low_half_load;
  logic [1:0]        fifo_count;
  logic              accept;
  logic              pop;
  logic              push;
  word_entry_t       push_entry;
  word_entry_t       head;

  // Ready uses only registered state so it never loops back through OUT_READY/FLUSH.
  assign IN_READY = RESET_L && ((state == LOW) || (fifo_count != 2'd2));
  assign accept   = IN_VALID && IN_READY;
  assign pop      = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state <= LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    push_entry    = '0;
    low_half_load = 1'b0;
    case (state)
      LOW: begin
        if (accept) begin
          low_half_load = 1'b1;
          state_nxt     = HIGH;
        end
      end
      HIGH: begin
        if (accept) begin
          push       = 1'b1;
          push_entry = make_entry(NIBBLE_IN, low_half, 1'b0);
          state_nxt  = LOW;
        end else if (FLUSH && (fifo_count != 2'd2)) begin
          push       = 1'b1;
          push_entry = make_entry('0, low_half, 1'b1);
          state_nxt  = LOW;
        end
      end
      default: state_nxt = LOW;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      low_half <= '0;
    end else if (low_half_load) begin
      low_half <= NIBBLE_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      WORD_COUNT <= '0;
    end else if (pop) begin
      WORD_COUNT <= WORD_COUNT + COUNT_W'(1);
    end
  end

  word_fifo2 u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_L),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (OUT_READY),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign OUT_VALID   = (fifo_count != 2'd0);
  assign DATA_OUT    = head.data;
  assign OUT_PARTIAL = head.partial;

endmodule
